breath_led_multi: RTL and testbench
===================================

// Module: breath_led_multi
// PURPOSE
//  Multi-channel breathing-LED PWM controller; parametrised successor of the single-channel breathing LED.
//  Drives CHANNELS LED outputs with a triangle-wave brightness envelope, adjustable per-channel phase offset
//  and a runtime display mode (breathe/on/off/blink). Sits beside the stopwatch display logic and runs on the board clock.
// PARAMETERS
//  CHANNELS   4    number of LED outputs
//  PWM_BITS   8    PWM/brightness resolution; frame = 2^PWM_BITS ticks
//  PRESCALE   196  clock cycles per PWM tick (>=1); 196 -> ~1 ms frame at 50 MHz
//  PHASE_STEP 64   phase offset added per channel index, in frames, modulo 2^(PWM_BITS+1)
// PORTS
//  CLK_50MHz  in   1         system clock, rising edge
//  reset_n    in   1         asynchronous active-low reset
//  enable     in   1         1 = run; 0 = all LEDs dark, all counters frozen
//  mode       in   2         00 breathe, 01 solid on, 10 off, 11 blink
//  led        out  CHANNELS  LED drive, active high, registered
// BEHAVIOUR
//  - Reset (async, reset_n=0): led=0, prescale_cnt=0, pwm_cnt=0, phase=0, mode_q=00. Released synchronously.
//  - prescale_cnt counts 0..PRESCALE-1 while enable=1; tick = (prescale_cnt==PRESCALE-1).
//  - pwm_cnt (PWM_BITS) increments on tick, wraps 2^PWM_BITS-1 -> 0; that wrap is the frame boundary.
//  - phase (PWM_BITS+1 bits) increments by 1 at each frame boundary, wraps naturally (period 2^(PWM_BITS+1) frames).
//  - Channel i: ph_i = phase + i*PHASE_STEP (mod 2^(PWM_BITS+1));
//    level_i = ph_i[MSB] ? ~ph_i[PWM_BITS-1:0] : ph_i[PWM_BITS-1:0] (triangle, 0 -> max -> 0).
//  - mode is sampled into mode_q only at frame boundaries (and at reset); a mid-frame change never makes a partial frame.
//  - Next-led per channel (registered, 1-cycle latency from the pwm_cnt value compared):
//      enable=0 -> 0;  mode_q=00 -> (pwm_cnt < level_i);  01 -> 1;  10 -> 0;  11 -> ~ph_i[MSB].
//  - level=0 gives a fully dark frame; level=2^PWM_BITS-1 gives high on all but one tick.
//  - enable=0: led goes 0 on the next clock edge; prescale_cnt/pwm_cnt/phase/mode_q hold. enable=1 resumes
//    from the held counts (no restart). A frame boundary is never taken while enable=0.
//  - Arithmetic unsigned; i*PHASE_STEP computed at elaboration, truncated to PWM_BITS+1 bits.
//  - Reset asserted mid-frame: outputs and all counters return to reset values immediately.
// CONFIGURATION
//  BREATH_GAMMA_EN defined: breathe-mode compare uses level_g = (level_i*level_i) >> PWM_BITS (perceptual gamma ~2),
//    full-width 2*PWM_BITS product, truncated to PWM_BITS after the shift.
//  Not defined: compare uses level_i directly (linear). Modes 01/10/11 unaffected either way.
// TESTING  (bench params: CHANNELS=2, PWM_BITS=4, PRESCALE=1, PHASE_STEP=16; frame=16 cycles, envelope=512 cycles)
//  1 reset_n=0 with clock running -> led=2'b00; release, enable=1, mode=00 -> frame 0: led[0] high 0/16 cycles,
//    led[1] (ph=16, level 15) high 15/16 cycles.
//  2 Free-run breathe -> frame k (0..15): led[0] high k cycles; frame 16+j: high 15-j cycles; frame 32 repeats frame 0
//    (phase wrap), led[1] always mirrors led[0] 16 frames apart.
//  3 enable 1->0 mid-frame (pwm_cnt=5) -> led=0 next edge; hold 100 cycles with pwm_cnt=5 frozen;
//    enable=1 -> PWM resumes at pwm_cnt=5, same frame duty as before.
//  4 mode=01 written at pwm_cnt=7 -> led unchanged until frame boundary, then 2'b11 continuously;
//    mode=10 -> 2'b00 from next frame; mode=11 -> led[0] high for frames 0..15, low 16..31; led[1] inverse.
//  5 reset_n pulse mid-envelope (frame 20, pwm_cnt=9) -> led=0 asynchronously, counters 0, mode_q=00; sequence restarts as test 1.
//  6 BREATH_GAMMA_EN defined, frame 8 (level 8) -> led[0] high 4/16 cycles; macro undefined -> 8/16 cycles.

Source files
------------

// File: rtl/breath_led_multi.sv
// ---------------------------------------------------------------------------
// breath_led_multi
//
// Multi-channel breathing-LED PWM controller. Every channel shares one
// prescaler, one PWM frame counter and one envelope phase counter; each
// channel sees the phase shifted by a fixed per-channel offset, so the
// channels breathe with staggered triangle-wave brightness envelopes.
//
// Timing chain:
//   prescale_cnt : 0..PRESCALE-1, one PWM tick when it reaches PRESCALE-1
//   pwm_cnt      : PWM_BITS wide, advances on each tick; its wrap from
//                  all-ones to 0 is the frame boundary
//   phase        : PWM_BITS+1 wide, advances once per frame; the MSB picks
//                  the rising or falling half of the triangle envelope
//
// Display mode is captured into mode_q only at frame boundaries, so a
// mode write never produces a partial frame.
//
// Ports:
//   CLK_50MHz  in   1         system clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   enable     in   1         1 = run; 0 = LEDs dark, all counters frozen
//   mode       in   2         00 breathe, 01 solid on, 10 off, 11 blink
//   led        out  CHANNELS  LED drive, active high, registered
//
// Valid/ready: this block has no handshakes. enable is a level qualifier:
// while it is low no counter moves and no frame boundary is taken.
//
// Optional build macro:
//   BREATH_GAMMA_EN  breathe mode compares against (level*level)>>PWM_BITS
//                    instead of the linear level (approximate gamma 2).
// ---------------------------------------------------------------------------
module breath_led_multi #(
   parameter int CHANNELS   = 4,
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE   = 196,
   parameter int PHASE_STEP = 64
) (
   input  logic                CLK_50MHz,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] led
);

   localparam int PH_W = PWM_BITS + 1;
   // A one-cycle prescaler still needs a 1-bit counter to exist.
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   localparam logic [1:0] MODE_BREATHE = 2'b00;
   localparam logic [1:0] MODE_ON      = 2'b01;
   localparam logic [1:0] MODE_OFF     = 2'b10;
   localparam logic [1:0] MODE_BLINK   = 2'b11;

   logic [PS_W-1:0]     r_prescale_cnt;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [PH_W-1:0]     r_phase;
   logic [1:0]          r_mode_q;
   logic [CHANNELS-1:0] r_led;

   logic                w_tick;
   logic                w_frame_end;
   logic [CHANNELS-1:0] w_led_next;

   // Ticks and frame boundaries are only ever taken while enabled, which
   // is what freezes the whole timing chain when enable drops.
   assign w_tick      = enable && (r_prescale_cnt == PS_MAX);
   assign w_frame_end = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});

   // -------------------------------------------------------------------
   // Timing chain: prescaler, PWM counter, envelope phase, mode capture
   // -------------------------------------------------------------------
   always_ff @(posedge CLK_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_prescale_cnt <= '0;
      end else if (enable) begin
         if (w_tick) begin
            r_prescale_cnt <= '0;
         end else begin
            r_prescale_cnt <= r_prescale_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;   // natural wrap marks the frame
      end
   end

   always_ff @(posedge CLK_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_phase  <= '0;
         r_mode_q <= MODE_BREATHE;
      end else if (w_frame_end) begin
         r_phase  <= r_phase + 1'b1;
         r_mode_q <= mode;
      end
   end

   // -------------------------------------------------------------------
   // Per-channel envelope and next-LED decision
   // -------------------------------------------------------------------
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Offset is fixed at elaboration and truncated to the phase width.
      localparam logic [PH_W-1:0] PH_OFF = PH_W'(gi * PHASE_STEP);

      logic [PH_W-1:0]     w_ph;
      logic [PWM_BITS-1:0] w_level;
      logic [PWM_BITS-1:0] w_cmp;

      assign w_ph = r_phase + PH_OFF;

      // Rising half counts up with phase; the falling half is the bitwise
      // complement, which mirrors it back down to zero.
      assign w_level = w_ph[PWM_BITS] ? ~w_ph[PWM_BITS-1:0]
                                      :  w_ph[PWM_BITS-1:0];

`ifdef BREATH_GAMMA_EN
      logic [2*PWM_BITS-1:0] w_sq;
      assign w_sq  = {{PWM_BITS{1'b0}}, w_level} * {{PWM_BITS{1'b0}}, w_level};
      assign w_cmp = PWM_BITS'(w_sq >> PWM_BITS);
`else
      assign w_cmp = w_level;
`endif

      // pwm_cnt < level: level 0 is a dark frame, all-ones level leaves
      // exactly one dark tick per frame.
      assign w_led_next[gi] =
         !enable                    ? 1'b0 :
         (r_mode_q == MODE_BREATHE) ? (r_pwm_cnt < w_cmp) :
         (r_mode_q == MODE_ON)      ? 1'b1 :
         (r_mode_q == MODE_OFF)     ? 1'b0 :
                                      ~w_ph[PWM_BITS];
   end

   // MODE_BLINK is the fall-through arm above; referenced here so the
   // full encoding stays visible in one place.
   logic w_unused_blink;
   assign w_unused_blink = (r_mode_q == MODE_BLINK);

   // -------------------------------------------------------------------
   // Output register: one cycle after the pwm_cnt value it compared
   // -------------------------------------------------------------------
   always_ff @(posedge CLK_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_led <= '0;
      end else begin
         r_led <= w_led_next;
      end
   end

   assign led = r_led;

endmodule

// File: tb/tb_breath_led_multi.sv
module tb_breath_led_multi;

   localparam int CH    = 2;
   localparam int PB    = 4;
   localparam int PS    = 1;
   localparam int STEP  = 16;
   localparam int FRAME = 1 << PB;
   localparam int ENV   = 2 * FRAME;

   // ---------------- clock / reset ----------------
   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable  = 1'b0;
   logic [1:0]    mode    = 2'b00;
   logic [CH-1:0] led;

   always #5 clk = ~clk;

   breath_led_multi #(
      .CHANNELS   (CH),
      .PWM_BITS   (PB),
      .PRESCALE   (PS),
      .PHASE_STEP (STEP)
   ) dut (
      .CLK_50MHz (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .mode      (mode),
      .led       (led)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int            n_vec = 0;
   int            n_err = 0;
   logic [CH-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks enabled ticks as plain integers: where we are in the frame,
   // which frame of the envelope, and the mode latched at the last frame.
   int m_presc  = 0;
   int m_pwm    = 0;
   int m_frame  = 0;
   int m_mode_q = 0;

   function automatic int tri_level(input int ph);
      int p;
      int lv;
      p  = ph % ENV;
      lv = (p < FRAME) ? p : (ENV - 1 - p);
`ifdef BREATH_GAMMA_EN
      lv = (lv * lv) / FRAME;
`endif
      return lv;
   endfunction

   function automatic logic [CH-1:0] model_led();
      logic [CH-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         int ph;
         ph = (m_frame + c * STEP) % ENV;
         if (!enable)            r[c] = 1'b0;
         else if (m_mode_q == 0) r[c] = (m_pwm < tri_level(ph));
         else if (m_mode_q == 1) r[c] = 1'b1;
         else if (m_mode_q == 2) r[c] = 1'b0;
         else                    r[c] = (ph < FRAME);
      end
      return r;
   endfunction

   task automatic model_reset();
      m_presc  = 0;
      m_pwm    = 0;
      m_frame  = 0;
      m_mode_q = 0;
      exp_q.delete();
   endtask

   task automatic model_advance();
      if (m_presc == PS - 1) begin
         m_presc = 0;
         if (m_pwm == FRAME - 1) begin
            m_pwm    = 0;
            m_frame  = (m_frame + 1) % ENV;
            m_mode_q = mode;
         end else begin
            m_pwm++;
         end
      end else begin
         m_presc++;
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock: predict from pre-edge state, clock, advance model, compare.
   task automatic cycle(input string tag);
      logic [CH-1:0] e;
      e = reset_n ? model_led() : '0;
      exp_q.push_back(e);
      @(posedge clk);
      if (reset_n && enable) model_advance();
      #1;
      check(tag, 32'(led), 32'(exp_q.pop_front()));
   endtask

   task automatic cycles(input int n, input string tag);
      for (int k = 0; k < n; k++) cycle(tag);
   endtask

   // Run until the model sits at pwm position p (and frame f if f >= 0).
   task automatic run_until(input int p, input int f, input string tag);
      int budget;
      budget = 4 * ENV * FRAME;
      while (!(m_pwm == p && m_presc == 0 && (f < 0 || m_frame == f)) && budget > 0) begin
         cycle(tag);
         budget--;
      end
      if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // One whole frame from pwm 0: count high cycles per channel.
   task automatic duty_frame(input int e0, input int e1, input string tag);
      int h0;
      int h1;
      h0 = 0;
      h1 = 0;
      for (int k = 0; k < FRAME * PS; k++) begin
         cycle(tag);
         h0 += int'(led[0]);
         h1 += int'(led[1]);
      end
      check({tag, "_duty0"}, 32'(h0), 32'(e0));
      check({tag, "_duty1"}, 32'(h1), 32'(e1));
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset_n = 1'b0;
      #1 check({tag, "_async"}, 32'(led), 32'd0);
      model_reset();
      cycles(2, {tag, "_held"});
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset with clock running, then first frame
      repeat (3) @(posedge clk);
      #1 check("reset_led", 32'(led), 32'd0);
      cycles(3, "reset_hold");
      model_reset();
      reset_n = 1'b1;
      enable  = 1'b1;
      mode    = 2'b00;
`ifdef BREATH_GAMMA_EN
      duty_frame(0, 14, "t1_frame0");
`else
      duty_frame(0, 15, "t1_frame0");
`endif

      // 2: free-running breathe envelope, frames 1..32 (32 == frame 0)
      for (int k = 1; k <= 32; k++) begin
         duty_frame(tri_level(k), tri_level(k + 16), $sformatf("t2_f%0d", k));
      end

      // 6: frame 8 of the next envelope, linear vs gamma duty
      run_until(0, 8, "t6_seek");
`ifdef BREATH_GAMMA_EN
      duty_frame(4, tri_level(24), "t6_gamma");
`else
      duty_frame(8, tri_level(24), "t6_linear");
`endif

      // 3: enable drop mid-frame, 100 frozen cycles, resume
      run_until(5, -1, "t3_seek");
      enable = 1'b0;
      cycles(100, "t3_frozen");
      enable = 1'b1;
      cycles(2 * FRAME, "t3_resume");

      // 4: mode changes mid-frame take effect at the next frame only
      run_until(7, -1, "t4_seek");
      mode = 2'b01;
      cycles(FRAME - 7, "t4_to_on");
      cycles(FRAME, "t4_on");
      check("t4_on_level", 32'(led), 32'h3);
      run_until(7, -1, "t4_seek_off");
      mode = 2'b10;
      cycles(2 * FRAME, "t4_off");
      check("t4_off_level", 32'(led), 32'h0);
      mode = 2'b11;
      cycles(ENV * FRAME + FRAME, "t4_blink");

      // 5: async reset mid-envelope, sequence restarts
      mode = 2'b00;
      run_until(9, 20, "t5_seek");
      async_reset_pulse("t5");
      enable = 1'b1;
`ifdef BREATH_GAMMA_EN
      duty_frame(0, 14, "t5_restart");
`else
      duty_frame(0, 15, "t5_restart");
`endif

      // random: mode writes, enable gaps, occasional resets
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: mode = 2'($urandom_range(0, 3));
            3, 4: begin
               enable = 1'b0;
               cycles($urandom_range(1, 20), "rnd_gap");
               enable = 1'b1;
            end
            5: async_reset_pulse("rnd_rst");
            default: ;
         endcase
         cycles($urandom_range(1, 60), "rnd_run");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
